// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: resolves control transfers, keeps a return-address
// stack, and holds the squash window after every taken redirect.
module pc_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int PC_STEP     = 4,
  parameter int RESET_PC    = 0,
  parameter int RAS_DEPTH   = 8,
  parameter int KILL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ZF,
  input  logic              NF,
  input  logic              Jump_F,
  input  logic              JR_F,
  input  logic              CLL,
  input  logic              RET,
  input  logic              BZ,
  input  logic              GZ,
  input  logic              LZ,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] PC,
  output logic [1:0]        PC_Src,
  output logic              Kill,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [2:0] KILL_LOAD = 3'(KILL_CYCLES - 1);
  localparam logic [CW-1:0] RAS_MAX = CW'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_top;
  logic [CW-1:0]     cnt;
  logic [2:0]        kill_cnt;

  logic              br_taken;
  logic              ctl_valid;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] next_pc;

  assign ptr_top   = ptr - PW'(1);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == RAS_MAX);
  assign br_taken  = (BZ & ZF) | (GZ & ~ZF & ~NF) | (LZ & NF);
  assign ctl_valid = ~stall & (kill_cnt == '0);
  assign Kill      = redirect | (kill_cnt != '0);

  // Control inputs are only honoured outside stalls and kill windows.
  always_comb begin
    PC_Src   = 2'b00;
    redirect = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    next_pc  = PC + ADDR_W'(PC_STEP);
    if (ctl_valid) begin
      if (RET) begin
        PC_Src   = 2'b10;
        redirect = 1'b1;
        pop      = 1'b1;
        next_pc  = ras_empty ? jr_target : ras_mem[ptr_top];
      end else if (JR_F) begin
        PC_Src   = 2'b10;
        redirect = 1'b1;
        next_pc  = jr_target;
      end else if (Jump_F | CLL) begin
        PC_Src   = 2'b11;
        redirect = 1'b1;
        push     = CLL;
        next_pc  = j_target;
      end else if (br_taken) begin
        PC_Src   = 2'b01;
        redirect = 1'b1;
        next_pc  = br_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC       <= ADDR_W'(RESET_PC);
      kill_cnt <= '0;
      ptr      <= '0;
      cnt      <= '0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
    end else if (!stall) begin
      PC <= next_pc;
      if (redirect)
        kill_cnt <= KILL_LOAD;
      else if (kill_cnt != '0)
        kill_cnt <= kill_cnt - 3'd1;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (ras_full)
          ras_ovf <= 1'b1;
        else
          cnt <= cnt + CW'(1);
      end else if (pop) begin
        if (ras_empty) begin
          ras_unf <= 1'b1;
        end else begin
          ptr <= ptr_top;
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  // Full pushes land on the oldest slot, which is where ptr already points.
  always_ff @(posedge clk) begin
    if (push && !reset)
      ras_mem[ptr] <= link_addr;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: one default instance and one with a deep kill window
// and a two-entry return stack, sharing the same stimulus.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        ZF = 1'b0, NF = 1'b0;
  logic        Jump_F = 1'b0, JR_F = 1'b0;
  logic        CLL = 1'b0, RET = 1'b0;
  logic        BZ = 1'b0, GZ = 1'b0, LZ = 1'b0;
  logic [31:0] br_target = '0, j_target = '0;
  logic [31:0] jr_target = '0, link_addr = '0;

  logic [31:0] a_pc, b_pc;
  logic [1:0]  a_src, b_src;
  logic        a_kill, b_kill;
  logic        a_empty, b_empty, a_full, b_full;
  logic        a_ovf, b_ovf, a_unf, b_unf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer dut_a (
    .clk(clk), .reset(reset), .stall(stall),
    .ZF(ZF), .NF(NF), .Jump_F(Jump_F), .JR_F(JR_F),
    .CLL(CLL), .RET(RET), .BZ(BZ), .GZ(GZ), .LZ(LZ),
    .br_target(br_target), .j_target(j_target),
    .jr_target(jr_target), .link_addr(link_addr),
    .PC(a_pc), .PC_Src(a_src), .Kill(a_kill),
    .ras_empty(a_empty), .ras_full(a_full),
    .ras_ovf(a_ovf), .ras_unf(a_unf)
  );

  pc_sequencer #(.RAS_DEPTH(2), .KILL_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .stall(stall),
    .ZF(ZF), .NF(NF), .Jump_F(Jump_F), .JR_F(JR_F),
    .CLL(CLL), .RET(RET), .BZ(BZ), .GZ(GZ), .LZ(LZ),
    .br_target(br_target), .j_target(j_target),
    .jr_target(jr_target), .link_addr(link_addr),
    .PC(b_pc), .PC_Src(b_src), .Kill(b_kill),
    .ras_empty(b_empty), .ras_full(b_full),
    .ras_ovf(b_ovf), .ras_unf(b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {ZF, NF, Jump_F, JR_F, CLL, RET, BZ, GZ, LZ} = '0;
    stall = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_src", 32'(a_src), 32'd0);
    chk("rst_kill", 32'(a_kill), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_unf", 32'(a_unf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("seq0", a_pc, 32'h0);
    tick();
    chk("seq1", a_pc, 32'h4);
    chk("seq1_kill", 32'(a_kill), 32'd0);
    tick();
    chk("seq2", a_pc, 32'h8);

    BZ = 1; ZF = 1; br_target = 32'h100; #1;
    chk("bz_src", 32'(a_src), 32'd1);
    chk("bz_kill", 32'(a_kill), 32'd1);
    tick(); clr(); #1;
    chk("bz_pc", a_pc, 32'h100);
    chk("bz_kill_end", 32'(a_kill), 32'd0);
    BZ = 1; ZF = 0; #1;
    chk("bz_nt_src", 32'(a_src), 32'd0);
    chk("bz_nt_kill", 32'(a_kill), 32'd0);
    tick(); clr();
    chk("bz_nt_pc", a_pc, 32'h104);

    GZ = 1; br_target = 32'h180; #1;
    chk("gz_src", 32'(a_src), 32'd1);
    tick(); clr();
    chk("gz_pc", a_pc, 32'h180);
    LZ = 1; GZ = 1; NF = 1; br_target = 32'h1C0; #1;
    chk("lz_src", 32'(a_src), 32'd1);
    tick(); clr();
    chk("lz_pc", a_pc, 32'h1C0);

    JR_F = 1; Jump_F = 1; jr_target = 32'h2A0; j_target = 32'h333; #1;
    chk("jr_pri_src", 32'(a_src), 32'd2);
    tick(); clr();
    chk("jr_pri_pc", a_pc, 32'h2A0);

    CLL = 1; j_target = 32'h200; link_addr = 32'h14; #1;
    chk("cll_src", 32'(a_src), 32'd3);
    chk("cll_kill", 32'(a_kill), 32'd1);
    tick(); clr();
    chk("cll_pc", a_pc, 32'h200);
    chk("cll_empty", 32'(a_empty), 32'd0);
    RET = 1; jr_target = 32'h777; #1;
    chk("ret_src", 32'(a_src), 32'd2);
    tick(); clr();
    chk("ret_pc", a_pc, 32'h14);
    chk("ret_empty", 32'(a_empty), 32'd1);
    chk("ret_unf", 32'(a_unf), 32'd0);

    RET = 1; CLL = 1; jr_target = 32'h50; j_target = 32'h600;
    link_addr = 32'h99; #1;
    chk("retcll_src", 32'(a_src), 32'd2);
    tick(); clr();
    chk("retcll_pc", a_pc, 32'h50);
    chk("retcll_empty", 32'(a_empty), 32'd1);
    chk("retcll_unf", 32'(a_unf), 32'd1);

    stall = 1; BZ = 1; ZF = 1; br_target = 32'h900; #1;
    chk("stl_src", 32'(a_src), 32'd0);
    chk("stl_kill", 32'(a_kill), 32'd0);
    tick();
    chk("stl_pc1", a_pc, 32'h50);
    tick();
    chk("stl_pc2", a_pc, 32'h50);
    clr();
    tick();
    chk("stl_rel_pc", a_pc, 32'h54);

    Jump_F = 1; j_target = 32'hFFFF_FFFC;
    tick(); clr();
    chk("wrap_top", a_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", a_pc, 32'h0);

    reset = 1; #1;
    chk("rst2_pc", b_pc, 32'h0);
    @(negedge clk);
    reset = 0;
    Jump_F = 1; j_target = 32'h40; #1;
    chk("kw_src", 32'(b_src), 32'd3);
    chk("kw_kill0", 32'(b_kill), 32'd1);
    tick(); clr();
    JR_F = 1; jr_target = 32'h999; #1;
    chk("kw_pc0", b_pc, 32'h40);
    chk("kw_kill1", 32'(b_kill), 32'd1);
    chk("kw_jr_src", 32'(b_src), 32'd0);
    tick(); clr();
    chk("kw_pc1", b_pc, 32'h44);
    chk("kw_kill2", 32'(b_kill), 32'd1);
    tick();
    chk("kw_pc2", b_pc, 32'h48);
    chk("kw_kill_end", 32'(b_kill), 32'd0);

    Jump_F = 1; j_target = 32'h80;
    tick(); clr();
    chk("ks_pc", b_pc, 32'h80);
    stall = 1; BZ = 1; ZF = 1; br_target = 32'h900; #1;
    chk("ks_src", 32'(b_src), 32'd0);
    chk("ks_kill", 32'(b_kill), 32'd1);
    tick();
    chk("ks_pc1", b_pc, 32'h80);
    tick();
    chk("ks_pc2", b_pc, 32'h80);
    chk("ks_kill2", 32'(b_kill), 32'd1);
    clr();
    tick();
    chk("ks_pc3", b_pc, 32'h84);
    chk("ks_kill3", 32'(b_kill), 32'd1);
    tick();
    chk("ks_pc4", b_pc, 32'h88);
    chk("ks_kill4", 32'(b_kill), 32'd0);

    CLL = 1; j_target = 32'h300; link_addr = 32'hA;
    tick(); clr(); tick(); tick();
    chk("ras1_empty", 32'(b_empty), 32'd0);
    chk("ras1_full", 32'(b_full), 32'd0);
    CLL = 1; j_target = 32'h310; link_addr = 32'hB;
    tick(); clr(); tick(); tick();
    chk("ras2_full", 32'(b_full), 32'd1);
    chk("ras2_ovf", 32'(b_ovf), 32'd0);
    CLL = 1; j_target = 32'h320; link_addr = 32'hC;
    tick(); clr(); tick(); tick();
    chk("ras3_ovf", 32'(b_ovf), 32'd1);
    chk("ras3_full", 32'(b_full), 32'd1);
    RET = 1; jr_target = 32'h555; #1;
    chk("pop1_src", 32'(b_src), 32'd2);
    tick(); clr();
    chk("pop1_pc", b_pc, 32'hC);
    tick(); tick();
    RET = 1;
    tick(); clr();
    chk("pop2_pc", b_pc, 32'hB);
    chk("pop2_empty", 32'(b_empty), 32'd1);
    tick(); tick();
    RET = 1; jr_target = 32'h500;
    tick(); clr();
    chk("pop3_pc", b_pc, 32'h500);
    chk("pop3_unf", 32'(b_unf), 32'd1);
    tick(); tick();

    Jump_F = 1; j_target = 32'h700;
    tick(); clr();
    chk("ar_pc_pre", b_pc, 32'h700);
    chk("ar_kill_pre", 32'(b_kill), 32'd1);
    #2 reset = 1; #1;
    chk("ar_pc", b_pc, 32'h0);
    chk("ar_kill", 32'(b_kill), 32'd0);
    chk("ar_ovf", 32'(b_ovf), 32'd0);
    chk("ar_unf", 32'(b_unf), 32'd0);
    chk("ar_empty", 32'(b_empty), 32'd1);
    @(negedge clk);
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
